xvk_mc_fifo: RTL and testbench

XVK_MC_FIFO -- requirements
Module: xvk_mc_fifo

---
 rtl/xvk_fifo_pkg.sv | 12 +
 rtl/xvk_mc_fifo_if.sv | 30 +++
 rtl/xvk_sdp_ram.sv | 38 +++
 rtl/xvk_mc_fifo.sv | 85 ++++++++
 tb/tb_xvk_mc_fifo.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/xvk_fifo_pkg.sv
// xvk_fifo_pkg: shared width helpers and RAM style constants for the FIFO family
package xvk_fifo_pkg;
  localparam RAM_DISTRIBUTED = "DISTRIBUTED";
  localparam RAM_BLOCK = "BLOCK";
  localparam RAM_ULTRA = "ULTRA";
  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cw(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/xvk_mc_fifo_if.sv
// xvk_mc_fifo_if: write, read, control and status bundle of the multi-channel FIFO
interface xvk_mc_fifo_if import xvk_fifo_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int NUM_CH = 4
);
  localparam int CHW = chw(NUM_CH);
  localparam int CW = cw(DEPTH);
  logic wr_en;
  logic [CHW-1:0] wr_ch;
  logic [WIDTH-1:0] din;
  logic rd_en;
  logic [CHW-1:0] rd_ch;
  logic [WIDTH-1:0] dout;
  logic dout_vld;
  logic [CHW-1:0] dout_ch;
  logic [NUM_CH-1:0] flush;
  logic err_clr;
  logic [NUM_CH-1:0] full, empty, prog_full;
  logic [NUM_CH*CW-1:0] count;
  logic [NUM_CH-1:0] overflow, underflow;
  modport master (
    output wr_en, wr_ch, din, rd_en, rd_ch, flush, err_clr,
    input dout, dout_vld, dout_ch, full, empty, prog_full, count, overflow, underflow
  );
  modport slave (
    input wr_en, wr_ch, din, rd_en, rd_ch, flush, err_clr,
    output dout, dout_vld, dout_ch, full, empty, prog_full, count, overflow, underflow
  );
endinterface

// File: rtl/xvk_sdp_ram.sv
// xvk_sdp_ram: simple dual-port RAM with registered read; the read register resets, the array does not
module xvk_sdp_ram import xvk_fifo_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int AW = 7,
  parameter RAM_TYPE = RAM_BLOCK
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic re,
  input  logic [AW-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);
  if (RAM_TYPE == RAM_ULTRA) begin : g_ultra
    (* ram_style = "ultra" *) logic [WIDTH-1:0] mem [0:(1<<AW)-1];
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (rst) rdata <= '0;
      else if (re) rdata <= mem[raddr];
    end
  end else if (RAM_TYPE == RAM_DISTRIBUTED) begin : g_dist
    (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [0:(1<<AW)-1];
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (rst) rdata <= '0;
      else if (re) rdata <= mem[raddr];
    end
  end else begin : g_block
    (* ram_style = "block" *) logic [WIDTH-1:0] mem [0:(1<<AW)-1];
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (rst) rdata <= '0;
      else if (re) rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/xvk_mc_fifo.sv
// xvk_mc_fifo: NUM_CH independent FIFOs sharing one RAM addressed {channel, pointer}
module xvk_mc_fifo import xvk_fifo_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int NUM_CH = 4,
  parameter int PROG_FULL = 30,
  parameter RAM_TYPE = RAM_BLOCK
) (
  input logic clk,
  input logic rst,
  xvk_mc_fifo_if.slave bus
);
  localparam int CHW = chw(NUM_CH);
  localparam int CW = cw(DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] PF_C = CW'(PROG_FULL);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "xvk_mc_fifo: DEPTH must be a power of two >= 2");
  end
  if (PROG_FULL < 1 || PROG_FULL > DEPTH) begin : g_bad_prog_full
    $fatal(1, "xvk_mc_fifo: PROG_FULL must be within 1..DEPTH");
  end
  logic [NUM_CH-1:0][PW-1:0] wr_ptr, rd_ptr;
  logic [NUM_CH-1:0][CW-1:0] cnt;
  logic [NUM_CH-1:0] wr_hit, rd_hit, ovf_set, udf_set;
  logic wr_ok, rd_ok;
  logic [WIDTH-1:0] rdata;
  // flags are masked while in reset so the status looks cleared before the first edge
  always_comb begin
    bus.empty = '0;
    bus.full = '0;
    bus.prog_full = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.empty[c] = rst || cnt[c] == '0;
      bus.full[c] = !rst && cnt[c] == DEPTH_C;
      bus.prog_full[c] = !rst && cnt[c] >= PF_C;
    end
  end
  assign bus.count = cnt;
  assign bus.dout = rdata;
  assign wr_ok = !rst && bus.wr_en && !bus.full[bus.wr_ch] && !bus.flush[bus.wr_ch];
  assign rd_ok = !rst && bus.rd_en && !bus.empty[bus.rd_ch] && !bus.flush[bus.rd_ch];
  assign wr_hit = wr_ok ? NUM_CH'(1) << bus.wr_ch : '0;
  assign rd_hit = rd_ok ? NUM_CH'(1) << bus.rd_ch : '0;
  assign ovf_set = (bus.wr_en && bus.full[bus.wr_ch] && !bus.flush[bus.wr_ch]) ? NUM_CH'(1) << bus.wr_ch : '0;
  assign udf_set = (!rst && bus.rd_en && bus.empty[bus.rd_ch] && !bus.flush[bus.rd_ch]) ? NUM_CH'(1) << bus.rd_ch : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      bus.dout_vld <= 1'b0;
      bus.dout_ch <= '0;
      bus.overflow <= '0;
      bus.underflow <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.flush[c]) begin
          wr_ptr[c] <= '0;
          rd_ptr[c] <= '0;
          cnt[c] <= '0;
        end else begin
          wr_ptr[c] <= wr_ptr[c] + PW'(wr_hit[c]);
          rd_ptr[c] <= rd_ptr[c] + PW'(rd_hit[c]);
          cnt[c] <= cnt[c] + CW'(wr_hit[c]) - CW'(rd_hit[c]);
        end
      end
      bus.dout_vld <= rd_ok;
      if (rd_ok) bus.dout_ch <= bus.rd_ch;
      bus.overflow <= (bus.err_clr ? '0 : bus.overflow) | ovf_set;
      bus.underflow <= (bus.err_clr ? '0 : bus.underflow) | udf_set;
    end
  end
  xvk_sdp_ram #(.WIDTH(WIDTH), .AW(CHW + PW), .RAM_TYPE(RAM_TYPE)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(wr_ok),
    .waddr({bus.wr_ch, wr_ptr[bus.wr_ch]}),
    .wdata(bus.din),
    .re(rd_ok),
    .raddr({bus.rd_ch, rd_ptr[bus.rd_ch]}),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_xvk_mc_fifo.sv
// tb_xvk_mc_fifo: directed self-checking bench for the multi-channel FIFO
module tb_xvk_mc_fifo;
  localparam int W = 16, D = 32, N = 4, CW = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  xvk_mc_fifo_if #(.WIDTH(W), .DEPTH(D), .NUM_CH(N)) bus();
  xvk_mc_fifo #(.WIDTH(W), .DEPTH(D), .NUM_CH(N), .PROG_FULL(30), .RAM_TYPE("BLOCK")) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.wr_en = 1'b0;
    bus.wr_ch = '0;
    bus.din = '0;
    bus.rd_en = 1'b0;
    bus.rd_ch = '0;
    bus.flush = '0;
    bus.err_clr = 1'b0;
  endtask
  task automatic wr(input int ch, input logic [15:0] d);
    bus.wr_en = 1'b1;
    bus.wr_ch = 2'(ch);
    bus.din = d;
    tick();
    bus.wr_en = 1'b0;
  endtask
  task automatic rd(input int ch);
    bus.rd_en = 1'b1;
    bus.rd_ch = 2'(ch);
    tick();
    bus.rd_en = 1'b0;
  endtask
  function automatic logic [CW-1:0] cnt(input int c);
    return bus.count[c*CW +: CW];
  endfunction
  initial begin
    idle();
    tick();
    tick();
    chk("rst_empty", 32'(bus.empty), 32'hF);
    chk("rst_full", 32'(bus.full), 32'h0);
    chk("rst_vld", 32'(bus.dout_vld), 32'h0);
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_dout", 32'(bus.dout), 32'h0);
    rst = 1'b0;
    // in-order read-back on channel 2
    for (int i = 0; i < 5; i++) wr(2, 16'(16'h10 + i));
    chk("c2_cnt5", 32'(cnt(2)), 32'd5);
    for (int i = 0; i < 5; i++) begin
      rd(2);
      chk("c2_dout", 32'(bus.dout), 32'(16'h10 + i));
      chk("c2_vld", 32'(bus.dout_vld), 32'h1);
      chk("c2_ch", 32'(bus.dout_ch), 32'h2);
    end
    tick();
    chk("c2_vld_off", 32'(bus.dout_vld), 32'h0);
    chk("c2_dout_hold", 32'(bus.dout), 32'h14);
    chk("c2_cnt0", 32'(cnt(2)), 32'd0);
    chk("c2_empty", 32'(bus.empty[2]), 32'h1);
    // fill channel 1 to full, then overflow
    for (int i = 0; i < 32; i++) begin
      wr(1, 16'(16'h100 + i));
      if (i == 28) chk("c1_pf_29", 32'(bus.prog_full[1]), 32'h0);
      if (i == 29) chk("c1_pf_30", 32'(bus.prog_full[1]), 32'h1);
    end
    chk("c1_full", 32'(bus.full), 32'h2);
    chk("c1_cnt32", 32'(cnt(1)), 32'd32);
    chk("c1_no_ovf", 32'(bus.overflow), 32'h0);
    wr(1, 16'h1FF);
    chk("c1_ovf", 32'(bus.overflow), 32'h2);
    chk("c1_cnt_hold", 32'(cnt(1)), 32'd32);
    bus.wr_en = 1'b1;
    bus.wr_ch = 2'd1;
    bus.din = 16'h1EE;
    rd(1);
    bus.wr_en = 1'b0;
    chk("c1_wr_rd_full", 32'(cnt(1)), 32'd31);
    chk("c1_dout_first", 32'(bus.dout), 32'h100);
    chk("c1_vld", 32'(bus.dout_vld), 32'h1);
    bus.flush = 4'b0010;
    tick();
    bus.flush = '0;
    chk("c1_flushed", 32'(cnt(1)), 32'd0);
    chk("c1_ovf_sticky", 32'(bus.overflow), 32'h2);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("ovf_cleared", 32'(bus.overflow), 32'h0);
    // underflow on channel 3 and clear/set priority
    rd(3);
    chk("c3_udf", 32'(bus.underflow), 32'h8);
    chk("c3_no_vld", 32'(bus.dout_vld), 32'h0);
    bus.err_clr = 1'b1;
    tick();
    chk("udf_cleared", 32'(bus.underflow), 32'h0);
    rd(3);
    bus.err_clr = 1'b0;
    chk("udf_set_wins", 32'(bus.underflow), 32'h8);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("udf_clear2", 32'(bus.underflow), 32'h0);
    // 40 writes through channel 0 to wrap pointers, channel 1 writes interleaved
    for (int i = 0; i < 40; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_ch = 2'd0;
      bus.din = 16'(16'h200 + i);
      bus.rd_en = (i > 0);
      bus.rd_ch = 2'd0;
      tick();
      idle();
      if (i > 0) chk("wrap_c0", 32'(bus.dout), 32'(16'h200 + i - 1));
      if (i < 4) wr(1, 16'(16'h300 + i));
    end
    rd(0);
    chk("wrap_c0_last", 32'(bus.dout), 32'h227);
    chk("wrap_c0_cnt", 32'(cnt(0)), 32'd0);
    for (int j = 0; j < 4; j++) begin
      rd(1);
      chk("c1_own_data", 32'(bus.dout), 32'(16'h300 + j));
      chk("c1_own_ch", 32'(bus.dout_ch), 32'h1);
    end
    // flush of channel 0 beats same-cycle write and read
    wr(1, 16'h400);
    wr(1, 16'h401);
    for (int i = 0; i < 5; i++) wr(0, 16'(16'h500 + i));
    chk("c0_cnt5", 32'(cnt(0)), 32'd5);
    bus.flush = 4'b0001;
    bus.wr_en = 1'b1;
    bus.wr_ch = 2'd0;
    bus.din = 16'h5FF;
    rd(0);
    idle();
    chk("flush_cnt", 32'(cnt(0)), 32'd0);
    chk("flush_no_vld", 32'(bus.dout_vld), 32'h0);
    chk("flush_no_ovf", 32'(bus.overflow), 32'h0);
    chk("flush_no_udf", 32'(bus.underflow), 32'h0);
    rd(1);
    chk("c1_intact0", 32'(bus.dout), 32'h400);
    rd(1);
    chk("c1_intact1", 32'(bus.dout), 32'h401);
    // reset behaviour
    wr(2, 16'h600);
    wr(2, 16'h601);
    chk("c2_cnt2", 32'(cnt(2)), 32'd2);
    rst = 1'b1;
    #1;
    chk("inrst_empty", 32'(bus.empty), 32'hF);
    rst = 1'b0;
    rd(2);
    chk("pre_rst_dout", 32'(bus.dout), 32'h600);
    chk("pre_rst_vld", 32'(bus.dout_vld), 32'h1);
    rst = 1'b1;
    bus.rd_en = 1'b1;
    bus.rd_ch = 2'd2;
    tick();
    rst = 1'b0;
    idle();
    chk("rst_vld_drop", 32'(bus.dout_vld), 32'h0);
    chk("rst_empty2", 32'(bus.empty), 32'hF);
    chk("rst_count2", 32'(bus.count), 32'h0);
    chk("rst_dout2", 32'(bus.dout), 32'h0);
    wr(2, 16'h700);
    rd(2);
    chk("post_rst_dout", 32'(bus.dout), 32'h700);
    chk("post_rst_ch", 32'(bus.dout_ch), 32'h2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
